// File: rtl/clk_mux_ctrl_nway.sv
// clk_mux_ctrl_nway
// Sequencer for glitch-free selection among NUM_CLK clock sources.
// A select request arrives on a valid/ready handshake. A real switch drops
// every gate enable for OFF_CYCLES cycles (break), then raises the new
// source's enable and waits ON_CYCLES cycles (make) before pulsing sel_done.
// Requests for the current source or for an out-of-range index answer in one
// cycle without touching the gates. All outputs come straight from flops.
`timescale 1ns/1ps

module clk_mux_ctrl_nway #(
  parameter int NUM_CLK    = 4,
  parameter int SEL_W      = $clog2(NUM_CLK),
  parameter int DEF_SEL    = 0,
  parameter int OFF_CYCLES = 8,
  parameter int ON_CYCLES  = 8,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sel_req_valid,
  input  logic [SEL_W-1:0]   sel_req_id,
  output logic               sel_req_ready,
  output logic               sel_done,
  output logic               err_bad_sel,
  output logic [NUM_CLK-1:0] gate_en,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               switching
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OFF  = 2'd1,
    ST_ON   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Counter reload values: the counter runs interval-1 down to zero.
  localparam logic [SEL_W-1:0] DEF_SEL_L = SEL_W'(DEF_SEL);
  localparam logic [CNT_W-1:0] OFF_LOAD  = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  // Decode a source index into a gate-enable vector.
  function automatic logic [NUM_CLK-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_CLK-1:0] v;
    v = {NUM_CLK{1'b0}};
    for (int i = 0; i < NUM_CLK; i++) begin
      if (SEL_W'(i) == idx) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  // An index is bad when it names a source that does not exist; only
  // possible when NUM_CLK is not a power of two.
  function automatic logic is_bad_sel(input logic [SEL_W-1:0] idx);
    return (int'(idx) >= NUM_CLK);
  endfunction

  state_t               state_q,     state_d;
  logic [SEL_W-1:0]     target_q,    target_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [NUM_CLK-1:0]   gate_en_q,   gate_en_d;
  logic [SEL_W-1:0]     cur_sel_q,   cur_sel_d;
  logic                 ready_q,     ready_d;
  logic                 done_q,      done_d;
  logic                 err_q,       err_d;
  logic                 switching_q, switching_d;

  // Next-state and next-output logic for the switch sequencer.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    gate_en_d   = gate_en_q;
    cur_sel_d   = cur_sel_q;
    ready_d     = ready_q;
    switching_d = switching_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sel_req_valid && ready_q) begin
          target_d = sel_req_id;
          ready_d  = 1'b0;
          if (is_bad_sel(sel_req_id)) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end else if (sel_req_id == cur_sel_q) begin
            state_d = ST_RESP;
            done_d  = 1'b1;
          end else begin
            // Break: every enable drops before the new one may rise.
            state_d     = ST_OFF;
            gate_en_d   = {NUM_CLK{1'b0}};
            switching_d = 1'b1;
            cnt_d       = OFF_LOAD;
          end
        end else begin
          ready_d = 1'b1;
        end
      end

      ST_OFF: begin
        if (cnt_q == CNT_ZERO) begin
          // Make: enable the target and report it as current together.
          state_d   = ST_ON;
          gate_en_d = onehot(target_q);
          cur_sel_d = target_q;
          cnt_d     = ON_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_ON: begin
        if (cnt_q == CNT_ZERO) begin
          state_d     = ST_RESP;
          done_d      = 1'b1;
          switching_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end

      default: begin
        // Unreachable encoding: fall back to a safe idle on the current source.
        state_d     = ST_IDLE;
        ready_d     = 1'b1;
        switching_d = 1'b0;
        gate_en_d   = onehot(cur_sel_q);
        cnt_d       = CNT_ZERO;
      end
    endcase
  end

  // State and output registers with synchronous reset to the default source.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      target_q    <= DEF_SEL_L;
      cnt_q       <= CNT_ZERO;
      gate_en_q   <= onehot(DEF_SEL_L);
      cur_sel_q   <= DEF_SEL_L;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      switching_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      gate_en_q   <= gate_en_d;
      cur_sel_q   <= cur_sel_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      switching_q <= switching_d;
    end
  end

  assign sel_req_ready = ready_q;
  assign sel_done      = done_q;
  assign err_bad_sel   = err_q;
  assign gate_en       = gate_en_q;
  assign cur_sel       = cur_sel_q;
  assign switching     = switching_q;

endmodule

// File: tb/tb_clk_mux_ctrl_nway.sv
// Self-checking bench for clk_mux_ctrl_nway: a 4-source instance checked every
// cycle against a transaction-level timing model, plus a 3-source instance for
// out-of-range selects. Directed tasks check the headline scenarios inline.
`timescale 1ns/1ps

module tb_clk_mux_ctrl_nway;

  localparam int OFF = 8;
  localparam int ON  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel_req_valid = 1'b0;
  logic [1:0] sel_req_id = 2'd0;
  logic       sel_req_ready, sel_done, err_bad_sel, switching;
  logic [3:0] gate_en;
  logic [1:0] cur_sel;

  logic       rst3 = 1'b1;
  logic       v3 = 1'b0;
  logic [1:0] id3 = 2'd0;
  logic       rdy3, done3, err3, sw3;
  logic [2:0] gate3;
  logic [1:0] cur3;

  int checks = 0;
  int errors = 0;

  clk_mux_ctrl_nway #(.NUM_CLK(4), .DEF_SEL(0), .OFF_CYCLES(OFF), .ON_CYCLES(ON), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sel_req_valid(sel_req_valid), .sel_req_id(sel_req_id),
    .sel_req_ready(sel_req_ready), .sel_done(sel_done), .err_bad_sel(err_bad_sel),
    .gate_en(gate_en), .cur_sel(cur_sel), .switching(switching));

  clk_mux_ctrl_nway #(.NUM_CLK(3), .DEF_SEL(0), .OFF_CYCLES(2), .ON_CYCLES(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst3), .sel_req_valid(v3), .sel_req_id(id3),
    .sel_req_ready(rdy3), .sel_done(done3), .err_bad_sel(err3),
    .gate_en(gate3), .cur_sel(cur3), .switching(sw3));

  always #5 clk = ~clk;

  // ---------------- transaction-level reference model ----------------
  // A transaction accepted at edge E occupies periods d = 1.. after it.
  int cyc = 0;
  int m_cur = 0, m_tgt = 0, m_kind = 0, m_E = 0, m_acc_cnt = 0;
  bit m_act = 0, m_ok = 0, m_rst_edge = 0;

  function automatic void exp_at(input int n, output logic [3:0] g, output int c,
                                 output bit rdy, output bit dn, output bit er, output bit sw);
    int d;
    g = 4'b0001 << m_cur; c = m_cur; rdy = 1'b1; dn = 1'b0; er = 1'b0; sw = 1'b0;
    if (m_act) begin
      d = n - m_E + 1;
      rdy = 1'b0;
      if (m_kind == 0) begin
        if (d <= OFF) begin
          g = 4'b0000; sw = 1'b1;
        end else if (d <= OFF + ON) begin
          g = 4'b0001 << m_tgt; c = m_tgt; sw = 1'b1;
        end else begin
          g = 4'b0001 << m_tgt; c = m_tgt; dn = 1'b1;
        end
      end else begin
        dn = (m_kind == 1);
        er = (m_kind == 2);
      end
    end
  endfunction

  initial begin
    logic [3:0] g; int c; bit r, dn, er, sw;
    forever begin
      @(posedge clk);
      exp_at(cyc, g, c, r, dn, er, sw);
      cyc = cyc + 1;
      m_rst_edge = rst;
      if (rst) begin
        m_ok = 1'b1; m_act = 1'b0; m_cur = 0;
      end else if (m_ok) begin
        if (m_act && (cyc - m_E + 1) >= ((m_kind == 0) ? OFF + ON + 2 : 2)) begin
          m_act = 1'b0;
          if (m_kind == 0) m_cur = m_tgt;
        end
        if (r && sel_req_valid) begin
          m_acc_cnt = m_acc_cnt + 1;
          m_E = cyc; m_act = 1'b1; m_tgt = int'(sel_req_id);
          m_kind = (m_tgt >= 4) ? 2 : ((m_tgt == m_cur) ? 1 : 0);
        end
      end
    end
  end

  // Continuous per-cycle comparison plus one-hot / break-before-make invariants.
  initial begin
    logic [3:0] g, prev_g; int c; bit r, dn, er, sw;
    logic [2:0] prev3;
    prev_g = 4'b0000; prev3 = 3'b000;
    forever begin
      @(negedge clk);
      if (m_ok) begin
        exp_at(cyc, g, c, r, dn, er, sw);
        checks++;
        if ({gate_en, cur_sel, sel_req_ready, sel_done, err_bad_sel, switching} !==
            {g, 2'(c), r, dn, er, sw}) begin
          errors++;
          $display("FAIL model cyc=%0d got gate=%b cur=%0d rdy=%b done=%b err=%b sw=%b want gate=%b cur=%0d rdy=%b done=%b err=%b sw=%b",
                   cyc, gate_en, cur_sel, sel_req_ready, sel_done, err_bad_sel, switching, g, c, r, dn, er, sw);
        end
        checks++;
        if ($countones(gate_en) > 1 || $countones(gate3) > 1) begin
          errors++;
          $display("FAIL onehot got gate=%b gate3=%b want at most one bit", gate_en, gate3);
        end
        if (!m_rst_edge) begin
          checks++;
          if (prev_g != 4'b0000 && gate_en != 4'b0000 && gate_en != prev_g) begin
            errors++;
            $display("FAIL bbm got %b after %b want zero in between", gate_en, prev_g);
          end
          if (prev3 != 3'b000 && gate3 != 3'b000 && gate3 != prev3) begin
            errors++;
            $display("FAIL bbm3 got %b after %b want zero in between", gate3, prev3);
          end
        end
        prev_g = gate_en; prev3 = gate3;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Raise a request and hold it until accepted; returns just after the accept edge.
  task automatic request(input logic [1:0] id);
    int n0;
    @(posedge clk); #1;
    sel_req_valid = 1'b1; sel_req_id = id;
    n0 = m_acc_cnt;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (m_acc_cnt != n0) break;
    end
    checks++;
    if (m_acc_cnt == n0) begin
      errors++;
      $display("FAIL accept_timeout id=%0d got no accept want accept within 60 cycles", id);
    end
    sel_req_valid = 1'b0;
    sel_req_id = 2'($urandom_range(0, 3));
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b1; rst3 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; rst3 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (gate_en !== 4'b0001 || cur_sel !== 2'd0 || sel_req_ready !== 1'b1 ||
          sel_done !== 1'b0 || err_bad_sel !== 1'b0 || switching !== 1'b0) begin
        errors++;
        $display("FAIL reset got gate=%b cur=%0d rdy=%b done=%b err=%b sw=%b want 0001 0 1 0 0 0",
                 gate_en, cur_sel, sel_req_ready, sel_done, err_bad_sel, switching);
      end
    end
  endtask

  task automatic test_switch();
    logic [3:0] eg; logic [1:0] ec;
    pulse_rst();
    request(2'd2);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      eg = (k <= OFF) ? 4'b0000 : 4'b0100;
      ec = (k <= OFF) ? 2'd0 : 2'd2;
      checks++;
      if (gate_en !== eg || cur_sel !== ec || sel_done !== (k == 17) || sel_req_ready !== (k == 18)) begin
        errors++;
        $display("FAIL switch k=%0d got gate=%b cur=%0d done=%b rdy=%b want gate=%b cur=%0d done=%b rdy=%b",
                 k, gate_en, cur_sel, sel_done, sel_req_ready, eg, ec, (k == 17), (k == 18));
      end
    end
  endtask

  task automatic test_same_sel();
    pulse_rst();
    request(2'd0);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++;
      if (gate_en !== 4'b0001 || sel_done !== (k == 1) || switching !== 1'b0 || sel_req_ready !== (k == 2)) begin
        errors++;
        $display("FAIL same_sel k=%0d got gate=%b done=%b sw=%b rdy=%b want 0001 %b 0 %b",
                 k, gate_en, sel_done, switching, sel_req_ready, (k == 1), (k == 2));
      end
    end
  endtask

  task automatic test_hold_valid();
    logic [3:0] eg; bit esw;
    pulse_rst();
    request(2'd3);
    sel_req_valid = 1'b1; sel_req_id = 2'd1;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (k <= 8) eg = 4'b0000;
      else if (k <= 18) eg = 4'b1000;
      else if (k <= 26) eg = 4'b0000;
      else eg = 4'b0010;
      esw = (k <= 16) || (k >= 19 && k <= 34);
      checks++;
      if (gate_en !== eg || switching !== esw || sel_req_ready !== (k == 18 || k == 36) ||
          sel_done !== (k == 17 || k == 35)) begin
        errors++;
        $display("FAIL hold_valid k=%0d got gate=%b sw=%b rdy=%b done=%b want gate=%b sw=%b rdy=%b done=%b",
                 k, gate_en, switching, sel_req_ready, sel_done, eg, esw, (k == 18 || k == 36), (k == 17 || k == 35));
      end
      if (k == 18) begin
        @(posedge clk); #1 sel_req_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_switch();
    pulse_rst();
    request(2'd2);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (gate_en !== 4'b0000 || switching !== 1'b1) begin
        errors++;
        $display("FAIL mid_off k=%0d got gate=%b sw=%b want 0000 1", k, gate_en, switching);
      end
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 5; k <= 22; k++) begin
      @(negedge clk);
      checks++;
      if (gate_en !== 4'b0001 || cur_sel !== 2'd0 || switching !== 1'b0 || sel_done !== 1'b0 ||
          sel_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid k=%0d got gate=%b cur=%0d sw=%b done=%b rdy=%b want 0001 0 0 0 1",
                 k, gate_en, cur_sel, switching, sel_done, sel_req_ready);
      end
    end
  endtask

  task automatic req3(input logic [1:0] id);
    @(posedge clk); #1 v3 = 1'b1; id3 = id;
    @(posedge clk); #1 v3 = 1'b0; id3 = 2'd1;
  endtask

  task automatic test_bad_sel();
    logic [2:0] eg; logic [1:0] ec;
    @(posedge clk); #1 rst3 = 1'b1;
    @(posedge clk); #1 rst3 = 1'b0;
    req3(2'd3);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      checks++;
      if (err3 !== (k == 1) || done3 !== 1'b0 || gate3 !== 3'b001 || cur3 !== 2'd0 || rdy3 !== (k == 2)) begin
        errors++;
        $display("FAIL bad_sel k=%0d got err=%b done=%b gate=%b cur=%0d rdy=%b want %b 0 001 0 %b",
                 k, err3, done3, gate3, cur3, rdy3, (k == 1), (k == 2));
      end
    end
    req3(2'd2);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      eg = (k <= 2) ? 3'b000 : 3'b100;
      ec = (k <= 2) ? 2'd0 : 2'd2;
      checks++;
      if (gate3 !== eg || cur3 !== ec || done3 !== (k == 6) || err3 !== 1'b0 || rdy3 !== (k == 7)) begin
        errors++;
        $display("FAIL sw3 k=%0d got gate=%b cur=%0d done=%b err=%b rdy=%b want gate=%b cur=%0d done=%b err=0 rdy=%b",
                 k, gate3, cur3, done3, err3, rdy3, eg, ec, (k == 6), (k == 7));
      end
    end
    req3(2'd3);
    @(negedge clk);
    checks++;
    if (err3 !== 1'b1 || done3 !== 1'b0 || gate3 !== 3'b100 || cur3 !== 2'd2) begin
      errors++;
      $display("FAIL bad_sel2 got err=%b done=%b gate=%b cur=%0d want 1 0 100 2", err3, done3, gate3, cur3);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      if ($urandom_range(0, 7) == 0) pulse_rst();
      request(2'($urandom_range(0, 3)));
    end
    repeat (25) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_switch();
    test_same_sel();
    test_hold_valid();
    test_reset_mid_switch();
    test_bad_sel();
    test_random();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
